// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin arbiter sharing one single-port BRAM.
// Client A and client B issue valid/ready requests. The winner drives the
// memory directly in the same cycle. A read is answered by a one-cycle
// rsp_valid strobe, and its data comes straight from the memory output.
module mem_arbiter #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset_n,
    // client A
    input  logic                     a_req_valid,
    output logic                     a_req_ready,
    input  logic                     a_req_write,
    input  logic [RAM_ADDR_BITS-1:0] a_req_addr,
    input  logic [RAM_WIDTH-1:0]     a_req_wdata,
    output logic                     a_rsp_valid,
    output logic [RAM_WIDTH-1:0]     a_rsp_rdata,
    // client B
    input  logic                     b_req_valid,
    output logic                     b_req_ready,
    input  logic                     b_req_write,
    input  logic [RAM_ADDR_BITS-1:0] b_req_addr,
    input  logic [RAM_WIDTH-1:0]     b_req_wdata,
    output logic                     b_rsp_valid,
    output logic [RAM_WIDTH-1:0]     b_rsp_rdata,
    // memory side
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    output logic [RAM_WIDTH-1:0]     input_data,
    input  logic [RAM_WIDTH-1:0]     output_data
);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_e;

    grant_e w_grant;
    logic   r_last_grant_b;   // 1: B won the most recent granted cycle
    logic   r_a_rsp_valid;
    logic   r_b_rsp_valid;

    // Pick the winner: a lone requester always wins, and under contention the client that did not go last wins.
    always_comb begin
        w_grant = GRANT_NONE;
        if (!reset_n) begin
            w_grant = GRANT_NONE;
        end else if (a_req_valid && b_req_valid) begin
            w_grant = r_last_grant_b ? GRANT_A : GRANT_B;
        end else if (a_req_valid) begin
            w_grant = GRANT_A;
        end else if (b_req_valid) begin
            w_grant = GRANT_B;
        end else begin
            w_grant = GRANT_NONE;
        end
    end

    // Route the winner to the memory and raise its ready. The A fields stay on the bus when idle.
    always_comb begin
        a_req_ready  = 1'b0;
        b_req_ready  = 1'b0;
        ram_enable   = 1'b0;
        write_enable = 1'b0;
        address      = a_req_addr;
        input_data   = a_req_wdata;
        case (w_grant)
            GRANT_A: begin
                a_req_ready  = 1'b1;
                ram_enable   = 1'b1;
                write_enable = a_req_write;
            end
            GRANT_B: begin
                b_req_ready  = 1'b1;
                ram_enable   = 1'b1;
                write_enable = b_req_write;
                address      = b_req_addr;
                input_data   = b_req_wdata;
            end
            default: begin
                a_req_ready  = 1'b0;
                b_req_ready  = 1'b0;
                ram_enable   = 1'b0;
                write_enable = 1'b0;
            end
        endcase
    end

    // Remember who was granted last. Reset points at B, so A wins the first contended cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant_b <= 1'b1;
        end else begin
            case (w_grant)
                GRANT_A: r_last_grant_b <= 1'b0;
                GRANT_B: r_last_grant_b <= 1'b1;
                default: r_last_grant_b <= r_last_grant_b;
            endcase
        end
    end

    // Single-cycle response strobe for an accepted read. It lines up with the BRAM's one-cycle latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
        end else begin
            r_a_rsp_valid <= (w_grant == GRANT_A) && !a_req_write;
            r_b_rsp_valid <= (w_grant == GRANT_B) && !b_req_write;
        end
    end

    assign a_rsp_valid = r_a_rsp_valid;
    assign b_rsp_valid = r_b_rsp_valid;
    assign a_rsp_rdata = output_data;
    assign b_rsp_rdata = output_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written reset sequences and a
// randomized run checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int W  = 32;
    localparam int AB = 9;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
    logic [AB-1:0] a_req_addr;
    logic [W-1:0]  a_req_wdata, a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
    logic [AB-1:0] b_req_addr;
    logic [W-1:0]  b_req_wdata, b_rsp_rdata;
    logic          ram_enable, write_enable;
    logic [AB-1:0] address;
    logic [W-1:0]  input_data, output_data;

    int checks = 0;
    int errors = 0;

    // behavioural single-port BRAM with a preload port for the bench
    logic [W-1:0]  mem [0:(1<<AB)-1];
    logic          pl_en = 1'b0;
    logic [AB-1:0] pl_addr = '0;
    logic [W-1:0]  pl_data = '0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_enable) begin
            if (write_enable) mem[address] <= input_data;
            output_data <= mem[address];
        end
    end

    mem_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .ram_enable(ram_enable), .write_enable(write_enable),
        .address(address), .input_data(input_data), .output_data(output_data)
    );

    typedef struct {
        logic          av, aw;
        logic [AB-1:0] aa;
        logic [W-1:0]  ad;
        logic          bv, bw;
        logic [AB-1:0] ba;
        logic [W-1:0]  bd;
        logic          e_ar, e_br, e_en, e_we;
        logic [AB-1:0] e_addr;
        logic [W-1:0]  e_din;
        logic          e_arsp, e_brsp;   // response from the previous row's access
        logic [W-1:0]  e_rdata;
    } vec_t;

    vec_t vecs [0:22];

    function automatic vec_t mk(
        input logic av, input logic aw, input logic [AB-1:0] aa, input logic [W-1:0] ad,
        input logic bv, input logic bw, input logic [AB-1:0] ba, input logic [W-1:0] bd,
        input logic ar, input logic br, input logic en, input logic we,
        input logic [AB-1:0] ea, input logic [W-1:0] ed,
        input logic arsp, input logic brsp, input logic [W-1:0] rd);
        vec_t v;
        v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
        v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd;
        v.e_ar = ar; v.e_br = br; v.e_en = en; v.e_we = we;
        v.e_addr = ea; v.e_din = ed;
        v.e_arsp = arsp; v.e_brsp = brsp; v.e_rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic aw, input logic [AB-1:0] aa, input logic [W-1:0] ad,
                         input logic bv, input logic bw, input logic [AB-1:0] ba, input logic [W-1:0] bd);
        a_req_valid = av; a_req_write = aw; a_req_addr = aa; a_req_wdata = ad;
        b_req_valid = bv; b_req_write = bw; b_req_addr = ba; b_req_wdata = bd;
    endtask

    // reference model state for the random phase
    logic [W-1:0]  ref_mem [0:15];
    bit            m_last_b;
    bit            m_arsp, m_brsp;
    logic [W-1:0]  m_rdata;
    bit            pa, pb, paw, pbw;
    logic [AB-1:0] paa, pba;
    logic [W-1:0]  pad, pbd;
    int            a_wait, b_wait, a_grants, b_grants;

    initial begin
        vec_t v;
        int   win;
        logic [AB-1:0] waddr;
        logic [W-1:0]  wdin;
        bit            wwr;

        // ---------------- directed vectors ----------------
        vecs[0]  = mk(1'b1,1'b1,9'd5,32'hDEADBEEF, 1'b0,1'b0,9'd0,32'd0, 1'b1,1'b0,1'b1,1'b1, 9'd5,32'hDEADBEEF, 1'b0,1'b0,32'd0);
        vecs[1]  = mk(1'b1,1'b0,9'd5,32'd0,        1'b0,1'b0,9'd0,32'd0, 1'b1,1'b0,1'b1,1'b0, 9'd5,32'd0,        1'b0,1'b0,32'd0);
        vecs[2]  = mk(1'b0,1'b0,9'd3,32'd0,        1'b0,1'b0,9'd0,32'd0, 1'b0,1'b0,1'b0,1'b0, 9'd3,32'd0,        1'b1,1'b0,32'hDEADBEEF);
        vecs[3]  = mk(1'b0,1'b0,9'd3,32'd0,        1'b1,1'b1,9'd1,32'd11,1'b0,1'b1,1'b1,1'b1, 9'd1,32'd11,       1'b0,1'b0,32'd0);
        vecs[4]  = mk(1'b0,1'b0,9'd3,32'd0,        1'b1,1'b1,9'd2,32'd22,1'b0,1'b1,1'b1,1'b1, 9'd2,32'd22,       1'b0,1'b0,32'd0);
        vecs[5]  = mk(1'b1,1'b0,9'd1,32'd0,        1'b1,1'b0,9'd2,32'd0, 1'b1,1'b0,1'b1,1'b0, 9'd1,32'd0,        1'b0,1'b0,32'd0);
        for (int i = 6; i <= 12; i++) begin
            if (i % 2 == 0)
                vecs[i] = mk(1'b1,1'b0,9'd1,32'd0, 1'b1,1'b0,9'd2,32'd0, 1'b0,1'b1,1'b1,1'b0, 9'd2,32'd0, 1'b1,1'b0,32'd11);
            else
                vecs[i] = mk(1'b1,1'b0,9'd1,32'd0, 1'b1,1'b0,9'd2,32'd0, 1'b1,1'b0,1'b1,1'b0, 9'd1,32'd0, 1'b0,1'b1,32'd22);
        end
        vecs[13] = mk(1'b0,1'b0,9'd3,32'd0, 1'b1,1'b1,9'd7,32'h55, 1'b0,1'b1,1'b1,1'b1, 9'd7,32'h55, 1'b0,1'b1,32'd22);
        vecs[14] = mk(1'b1,1'b0,9'd7,32'd0, 1'b0,1'b0,9'd0,32'd0,  1'b1,1'b0,1'b1,1'b0, 9'd7,32'd0,  1'b0,1'b0,32'd0);
        vecs[15] = mk(1'b0,1'b0,9'd3,32'd0, 1'b0,1'b0,9'd0,32'd0,  1'b0,1'b0,1'b0,1'b0, 9'd3,32'd0,  1'b1,1'b0,32'h55);
        vecs[16] = mk(1'b0,1'b0,9'd3,32'd0, 1'b1,1'b0,9'd7,32'd0,  1'b0,1'b1,1'b1,1'b0, 9'd7,32'd0,  1'b0,1'b0,32'd0);
        vecs[17] = mk(1'b0,1'b0,9'd3,32'd0, 1'b0,1'b0,9'd0,32'd0,  1'b0,1'b0,1'b0,1'b0, 9'd3,32'd0,  1'b0,1'b1,32'h55);
        vecs[18] = mk(1'b0,1'b0,9'd3,32'd0, 1'b0,1'b0,9'd0,32'd0,  1'b0,1'b0,1'b0,1'b0, 9'd3,32'd0,  1'b0,1'b0,32'd0);
        vecs[19] = vecs[18];
        vecs[20] = mk(1'b1,1'b0,9'd1,32'd0, 1'b1,1'b0,9'd2,32'd0,  1'b1,1'b0,1'b1,1'b0, 9'd1,32'd0,  1'b0,1'b0,32'd0);
        vecs[21] = mk(1'b0,1'b0,9'd3,32'd0, 1'b1,1'b0,9'd2,32'd0,  1'b0,1'b1,1'b1,1'b0, 9'd2,32'd0,  1'b1,1'b0,32'd11);
        vecs[22] = mk(1'b0,1'b0,9'd3,32'd0, 1'b0,1'b0,9'd0,32'd0,  1'b0,1'b0,1'b0,1'b0, 9'd3,32'd0,  1'b0,1'b1,32'd22);

        // ---------------- reset with both clients requesting ----------------
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 9'd0, 32'd0, 1'b1, 1'b0, 9'd0, 32'd0);
        #1;
        chk("rst_a_ready", {31'd0, a_req_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_req_ready}, 32'd0);
        chk("rst_ram_en",  {31'd0, ram_enable},  32'd0);
        chk("rst_wr_en",   {31'd0, write_enable}, 32'd0);
        @(posedge clock); #1;
        chk("rst_a_rsp",   {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_b_rsp",   {31'd0, b_rsp_valid}, 32'd0);
        chk("rst_ram_en2", {31'd0, ram_enable},  32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 9'd0, 32'd0);
        #1;
        chk("first_grant_a", {31'd0, a_req_ready}, 32'd1);
        chk("first_grant_b", {31'd0, b_req_ready}, 32'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
        #1;
        chk("first_rsp_a", {31'd0, a_rsp_valid}, 32'd1);
        chk("first_rsp_b", {31'd0, b_rsp_valid}, 32'd0);

        // ---------------- table-driven directed vectors ----------------
        for (int i = 0; i <= 22; i++) begin
            v = vecs[i];
            @(negedge clock);
            drive(v.av, v.aw, v.aa, v.ad, v.bv, v.bw, v.ba, v.bd);
            #1;
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_req_ready}, {31'd0, v.e_ar});
            chk($sformatf("v%0d_b_ready", i), {31'd0, b_req_ready}, {31'd0, v.e_br});
            chk($sformatf("v%0d_ram_en", i),  {31'd0, ram_enable},  {31'd0, v.e_en});
            chk($sformatf("v%0d_wr_en", i),   {31'd0, write_enable}, {31'd0, v.e_we});
            chk($sformatf("v%0d_addr", i),    {23'd0, address},     {23'd0, v.e_addr});
            chk($sformatf("v%0d_din", i),     input_data,           v.e_din);
            chk($sformatf("v%0d_a_rsp", i),   {31'd0, a_rsp_valid}, {31'd0, v.e_arsp});
            chk($sformatf("v%0d_b_rsp", i),   {31'd0, b_rsp_valid}, {31'd0, v.e_brsp});
            if (v.e_arsp) chk($sformatf("v%0d_a_rdata", i), a_rsp_rdata, v.e_rdata);
            if (v.e_brsp) chk($sformatf("v%0d_b_rdata", i), b_rsp_rdata, v.e_rdata);
        end

        // ---------------- reset in the middle of a read ----------------
        @(negedge clock);
        drive(1'b1, 1'b0, 9'd1, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
        @(posedge clock); #1;
        chk("mid_rsp_before", {31'd0, a_rsp_valid}, 32'd1);
        chk("mid_rdata",      a_rsp_rdata,          32'd11);
        reset_n = 1'b0;      // A still presents its next read
        #1;
        chk("mid_rsp_drop",   {31'd0, a_rsp_valid}, 32'd0);
        chk("mid_ready_low",  {31'd0, a_req_ready}, 32'd0);
        chk("mid_en_low",     {31'd0, ram_enable},  32'd0);
        @(posedge clock); #1;
        chk("mid_rsp_in_rst", {31'd0, a_rsp_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
        #1;
        chk("post_rst_rsp_a", {31'd0, a_rsp_valid}, 32'd0);
        @(posedge clock); #1;
        chk("post_rst_stale", {31'd0, a_rsp_valid}, 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 9'd2, 32'd0, 1'b1, 1'b0, 9'd1, 32'd0);
        #1;
        chk("post_rst_grant_a", {31'd0, a_req_ready}, 32'd1);
        chk("post_rst_grant_b", {31'd0, b_req_ready}, 32'd0);

        // ---------------- randomized run against the reference model ----------------
        @(negedge clock);
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            pl_en = 1'b1; pl_addr = AB'(i); pl_data = $urandom;
            ref_mem[i] = pl_data;
            @(negedge clock);
        end
        pl_en = 1'b0;
        reset_n = 1'b1;
        m_last_b = 1'b1; m_arsp = 1'b0; m_brsp = 1'b0; m_rdata = '0;
        pa = 1'b0; pb = 1'b0; paw = 1'b0; pbw = 1'b0; paa = '0; pba = '0; pad = '0; pbd = '0;
        a_wait = 0; b_wait = 0; a_grants = 0; b_grants = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            if (!pa && $urandom_range(0, 9) < 7) begin
                pa = 1'b1; paw = 1'($urandom_range(0, 1)); paa = AB'($urandom_range(0, 15)); pad = $urandom;
            end
            if (!pb && $urandom_range(0, 9) < 7) begin
                pb = 1'b1; pbw = 1'($urandom_range(0, 1)); pba = AB'($urandom_range(0, 15)); pbd = $urandom;
            end
            drive(pa, paw, paa, pad, pb, pbw, pba, pbd);
            #1;
            // winner: the only waiting client, or the one that did not go last
            if (pa && pb) win = m_last_b ? 1 : 2;
            else if (pa)  win = 1;
            else if (pb)  win = 2;
            else          win = 0;
            waddr = (win == 2) ? pba : paa;
            wdin  = (win == 2) ? pbd : pad;
            wwr   = (win == 1) ? paw : ((win == 2) ? pbw : 1'b0);

            chk("rnd_a_ready", {31'd0, a_req_ready}, (win == 1) ? 32'd1 : 32'd0);
            chk("rnd_b_ready", {31'd0, b_req_ready}, (win == 2) ? 32'd1 : 32'd0);
            chk("rnd_ram_en",  {31'd0, ram_enable},  (win != 0) ? 32'd1 : 32'd0);
            chk("rnd_wr_en",   {31'd0, write_enable}, {31'd0, wwr});
            chk("rnd_addr",    {23'd0, address},     {23'd0, waddr});
            chk("rnd_din",     input_data,           wdin);
            chk("rnd_a_rsp",   {31'd0, a_rsp_valid}, {31'd0, m_arsp});
            chk("rnd_b_rsp",   {31'd0, b_rsp_valid}, {31'd0, m_brsp});
            if (m_arsp) chk("rnd_a_rdata", a_rsp_rdata, m_rdata);
            if (m_brsp) chk("rnd_b_rdata", b_rsp_rdata, m_rdata);

            // a waiting client never waits more than one cycle
            a_wait = (pa && win != 1) ? a_wait + 1 : 0;
            b_wait = (pb && win != 2) ? b_wait + 1 : 0;
            chk("rnd_a_wait", (a_wait <= 1) ? 32'd1 : 32'd0, 32'd1);
            chk("rnd_b_wait", (b_wait <= 1) ? 32'd1 : 32'd0, 32'd1);

            m_arsp = 1'b0; m_brsp = 1'b0;
            if (win != 0) begin
                m_last_b = (win == 2);
                if (wwr) begin
                    ref_mem[waddr[3:0]] = wdin;
                end else begin
                    m_rdata = ref_mem[waddr[3:0]];
                    if (win == 1) m_arsp = 1'b1; else m_brsp = 1'b1;
                end
                if (win == 1) begin pa = 1'b0; a_grants++; end
                else          begin pb = 1'b0; b_grants++; end
            end
        end
        chk("rnd_a_got_grants", (a_grants > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("rnd_b_got_grants", (b_grants > 0) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
